// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo up/down counter with clear, load, saturate and carry chaining
module mod_updown_counter #(
    parameter int     WIDTH       = 8,
    parameter longint MODULUS     = 60,
    parameter int     SATURATE    = 0,
    parameter longint RESET_VALUE = 0
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry,
    output logic             o_wrapped,
    output logic             o_at_max,
    output logic             o_at_min
);

    // Bounds are formed in 64 bits first so MODULUS = 2^WIDTH (up to 2^32) never overflows.
    localparam logic [63:0]      MAX_64  = 64'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_64[WIDTH-1:0];
    localparam logic [63:0]      RST_64  = 64'(RESET_VALUE);
    localparam logic [WIDTH-1:0] RST_VAL = RST_64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam bit               SAT     = (SATURATE != 0);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("mod_updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be 2..2^WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset_value
        $error("mod_updown_counter: RESET_VALUE must be below MODULUS");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrapped;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_at_bound;

    assign w_at_max   = (r_count == MAX_VAL);
    assign w_at_min   = (r_count == '0);
    assign w_at_bound = i_dir ? w_at_max : w_at_min;

    always_comb begin
        w_next_count   = r_count;
        w_next_wrapped = 1'b0;
        if (i_clr) begin
            w_next_count = '0;
        end else if (i_load) begin
            w_next_count = (i_load_value > MAX_VAL) ? MAX_VAL : i_load_value;
        end else if (i_en) begin
            if (w_at_bound) begin
                // At a bound: saturating builds hold, wrapping builds jump to the opposite bound.
                if (!SAT) begin
                    w_next_count   = i_dir ? '0 : MAX_VAL;
                    w_next_wrapped = 1'b1;
                end
            end else if (i_dir) begin
                w_next_count = r_count + ONE;
            end else begin
                w_next_count = r_count - ONE;
            end
        end
    end

    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_count   <= RST_VAL;
            r_wrapped <= 1'b0;
        end else begin
            r_count   <= w_next_count;
            r_wrapped <= w_next_wrapped;
        end
    end

    // Carry is combinational so a downstream stage steps on the same edge this stage wraps.
    assign o_carry   = i_en & ~i_clr & ~i_load & ~SAT & w_at_bound;
    assign o_count   = r_count;
    assign o_wrapped = r_wrapped;
    assign o_at_max  = w_at_max;
    assign o_at_min  = w_at_min;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - directed self-checking bench for mod_updown_counter
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       g_rst;

    logic       a_clr, a_load, a_en, a_dir;
    logic [7:0] a_lv, a_count;
    logic       a_carry, a_wrapped, a_max, a_min;

    logic       s_clr, s_load, s_en, s_dir;
    logic [3:0] s_lv, s_count;
    logic       s_carry, s_wrapped, s_max, s_min;

    logic       r_rst, r_clr, r_load, r_en, r_dir;
    logic [7:0] r_lv, r_count;
    logic       r_carry, r_wrapped, r_max, r_min;

    logic       c_en, c_zero, c_one;
    logic [3:0] c_lv, lo_count, hi_count;
    logic       lo_carry, lo_wrapped, lo_max, lo_min;
    logic       hi_carry, hi_wrapped, hi_max, hi_min;

    mod_updown_counter u_a (
        .i_sysclk(clk), .i_reset(g_rst), .i_clr(a_clr), .i_load(a_load),
        .i_load_value(a_lv), .i_en(a_en), .i_dir(a_dir), .o_count(a_count),
        .o_carry(a_carry), .o_wrapped(a_wrapped), .o_at_max(a_max), .o_at_min(a_min)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VALUE(0)) u_s (
        .i_sysclk(clk), .i_reset(g_rst), .i_clr(s_clr), .i_load(s_load),
        .i_load_value(s_lv), .i_en(s_en), .i_dir(s_dir), .o_count(s_count),
        .o_carry(s_carry), .o_wrapped(s_wrapped), .o_at_max(s_max), .o_at_min(s_min)
    );

    mod_updown_counter #(.WIDTH(8), .MODULUS(38), .SATURATE(0), .RESET_VALUE(5)) u_r (
        .i_sysclk(clk), .i_reset(r_rst), .i_clr(r_clr), .i_load(r_load),
        .i_load_value(r_lv), .i_en(r_en), .i_dir(r_dir), .o_count(r_count),
        .o_carry(r_carry), .o_wrapped(r_wrapped), .o_at_max(r_max), .o_at_min(r_min)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .i_sysclk(clk), .i_reset(g_rst), .i_clr(c_zero), .i_load(c_zero),
        .i_load_value(c_lv), .i_en(c_en), .i_dir(c_one), .o_count(lo_count),
        .o_carry(lo_carry), .o_wrapped(lo_wrapped), .o_at_max(lo_max), .o_at_min(lo_min)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .i_sysclk(clk), .i_reset(g_rst), .i_clr(c_zero), .i_load(c_zero),
        .i_load_value(c_lv), .i_en(lo_carry), .i_dir(c_one), .o_count(hi_count),
        .o_carry(hi_carry), .o_wrapped(hi_wrapped), .o_at_max(hi_max), .o_at_min(hi_min)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        g_rst = 1'b1; r_rst = 1'b1;
        a_clr = 0; a_load = 0; a_en = 0; a_dir = 1; a_lv = 0;
        s_clr = 0; s_load = 0; s_en = 0; s_dir = 1; s_lv = 0;
        r_clr = 0; r_load = 0; r_en = 0; r_dir = 1; r_lv = 0;
        c_en = 0; c_zero = 0; c_one = 1; c_lv = 0;

        // Reset asserted: clocks and enables must be ignored.
        a_en = 1;
        #1;
        check("rst_a_count", a_count, 0);
        check("rst_r_count", r_count, 5);
        step();
        step();
        check("rst_a_count_held", a_count, 0);
        check("rst_a_wrapped", a_wrapped, 0);
        check("rst_a_min", a_min, 1);
        check("rst_a_max", a_max, 0);
        check("rst_r_count_held", r_count, 5);
        check("rst_r_min", r_min, 0);

        // Default up-count wrap over 61 edges.
        g_rst = 0; a_en = 1; a_dir = 1;
        #1;
        for (int i = 0; i <= 60; i++) begin
            check($sformatf("up_count_%0d", i), a_count, i % 60);
            check($sformatf("up_carry_%0d", i), a_carry, (i == 59) ? 1 : 0);
            check($sformatf("up_max_%0d", i), a_max, (i == 59) ? 1 : 0);
            check($sformatf("up_wrapped_%0d", i), a_wrapped, (i == 60) ? 1 : 0);
            step();
            #1;
        end
        check("up_after_count", a_count, 1);
        check("up_after_wrapped", a_wrapped, 0);

        // Hold with enable low.
        a_en = 0;
        step();
        step();
        check("hold_count", a_count, 1);
        check("hold_wrapped", a_wrapped, 0);

        // Down-count wrap from a loaded 1.
        a_load = 1; a_lv = 1;
        step();
        a_load = 0; a_en = 1; a_dir = 0;
        #1;
        begin
            logic [7:0] dn_exp [4];
            dn_exp = '{8'd1, 8'd0, 8'd59, 8'd58};
            for (int k = 0; k < 4; k++) begin
                check($sformatf("dn_count_%0d", k), a_count, dn_exp[k]);
                check($sformatf("dn_min_%0d", k), a_min, (k == 1) ? 1 : 0);
                check($sformatf("dn_carry_%0d", k), a_carry, (k == 1) ? 1 : 0);
                check($sformatf("dn_wrapped_%0d", k), a_wrapped, (k == 2) ? 1 : 0);
                if (k < 3) begin
                    step();
                    #1;
                end
            end
        end

        // Load clamping, then clr beats load beats en.
        a_en = 0; a_load = 1; a_lv = 200;
        step();
        a_load = 0;
        #1;
        check("clamp_count", a_count, 59);
        check("clamp_max", a_max, 1);
        a_clr = 1; a_load = 1; a_en = 1; a_dir = 1; a_lv = 5;
        #1;
        check("prio_carry", a_carry, 0);
        step();
        a_clr = 0; a_load = 0; a_en = 0;
        #1;
        check("prio_count", a_count, 0);
        check("prio_wrapped", a_wrapped, 0);
        a_load = 1; a_lv = 42; a_en = 1;
        step();
        a_load = 0; a_en = 0;
        #1;
        check("load_over_en", a_count, 42);

        // Saturation: MODULUS=10 holds at 9 and at 0.
        s_en = 1; s_dir = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            #1;
            check($sformatf("sat_up_%0d", i), s_count, (i + 1 > 9) ? 9 : i + 1);
            check($sformatf("sat_up_carry_%0d", i), s_carry, 0);
            check($sformatf("sat_up_wrapped_%0d", i), s_wrapped, 0);
        end
        check("sat_up_max", s_max, 1);
        s_dir = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            #1;
            check($sformatf("sat_dn_%0d", i), s_count, (i >= 8) ? 0 : 8 - i);
            check($sformatf("sat_dn_carry_%0d", i), s_carry, 0);
            check($sformatf("sat_dn_wrapped_%0d", i), s_wrapped, 0);
        end
        s_en = 0;

        // Async reset between edges at count=37 while wrapped is high.
        r_rst = 0; r_load = 1; r_lv = 0;
        step();
        r_load = 0; r_en = 1; r_dir = 0;
        step();
        check("rr_count_37", r_count, 37);
        check("rr_wrapped_1", r_wrapped, 1);
        #3;
        r_rst = 1;
        #1;
        check("rr_async_count", r_count, 5);
        check("rr_async_wrapped", r_wrapped, 0);
        check("rr_async_max", r_max, 0);
        r_clr = 1; r_load = 1; r_lv = 20;
        step();
        check("rr_ignore_count", r_count, 5);
        r_rst = 0; r_clr = 0; r_load = 0; r_en = 1; r_dir = 1;
        step();
        check("rr_resume_count", r_count, 6);
        check("rr_resume_wrapped", r_wrapped, 0);
        r_en = 0;

        // Two-stage full-range cascade.
        c_en = 1;
        #1;
        for (int i = 0; i <= 256; i++) begin
            check($sformatf("casc_%0d", i), {24'd0, hi_count, lo_count}, i % 256);
            step();
            #1;
        end
        c_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter bit width, legal range 1..32.
REQ-002 SHALL have parameter MODULUS, default 60: count range is 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 wraps at the bounds, 1 holds at the bounds.
REQ-004 SHALL have parameter RESET_VALUE, default 0: value of o_count after reset, required to be < MODULUS.
REQ-005 SHALL have port i_sysclk, input, 1 bit: the single system clock, rising-edge active.
REQ-006 SHALL have port i_reset, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port i_clr, input, 1 bit: synchronous clear to 0.
REQ-008 SHALL have port i_load, input, 1 bit: synchronous load of i_load_value.
REQ-009 SHALL have port i_load_value, input, WIDTH bits: load data.
REQ-010 SHALL have port i_en, input, 1 bit: count enable (chainable from an upstream o_carry).
REQ-011 SHALL have port i_dir, input, 1 bit: 1 counts up, 0 counts down.
REQ-012 SHALL have port o_count, output, WIDTH bits: current count (registered).
REQ-013 SHALL have port o_carry, output, 1 bit: combinational; a wrap occurs at the next edge.
REQ-014 SHALL have port o_wrapped, output, 1 bit: registered one-cycle pulse asserted after a wrap.
REQ-015 SHALL have port o_at_max, output, 1 bit: combinational; o_count == MODULUS-1.
REQ-016 SHALL have port o_at_min, output, 1 bit: combinational; o_count == 0.

Function
REQ-017 SHALL apply per-edge priority: i_clr > i_load > i_en > hold.
REQ-018 SHALL, on i_clr, set o_count to 0 and o_wrapped to 0.
REQ-019 SHALL, on i_load, set o_count to i_load_value if it is < MODULUS, else to MODULUS-1; o_wrapped goes to 0.
REQ-020 SHALL, on i_en with i_dir=1 and o_count < MODULUS-1, increment o_count by 1.
REQ-021 SHALL, on i_en with i_dir=0 and o_count > 0, decrement o_count by 1.
REQ-022 SHALL, with SATURATE=0, step from MODULUS-1 to 0 on up-count and from 0 to MODULUS-1 on down-count, and set o_wrapped=1 for the next cycle only.
REQ-023 SHALL, with SATURATE=1, hold o_count at the bound instead of wrapping; o_carry and o_wrapped stay 0.
REQ-024 SHALL drive o_carry = i_en & ~i_clr & ~i_load & ~SATURATE & ((i_dir & o_at_max) | (~i_dir & o_at_min)), so that a chained stage advances in the same cycle as this stage wraps.
REQ-025 SHALL produce o_wrapped=0 on any edge without a wrap, including when i_en is held.
REQ-026 SHALL allow i_dir to change on any cycle; only its value at the active edge matters.
REQ-027 SHALL compute every next-state value in WIDTH bits with no intermediate overflow, including MODULUS=2^WIDTH, where MODULUS-1 is all ones.
REQ-028 SHALL leave o_count unchanged when i_en=0, i_clr=0 and i_load=0.

Reset
REQ-029 SHALL, while i_reset=1, force o_count=RESET_VALUE and o_wrapped=0 immediately, independent of i_sysclk.
REQ-030 SHALL ignore i_clr, i_load and i_en while i_reset is asserted.
REQ-031 SHALL resume normal operation on the first rising edge after i_reset deasserts.
REQ-032 SHALL abort an in-progress o_wrapped pulse when reset is asserted.
REQ-033 SHALL derive o_carry, o_at_max and o_at_min from the reset value during reset.

Verification
REQ-034 SHALL verify the default up-count wrap: i_en=1, i_dir=1 for 61 clocks from 0 -> count 0..59 then 0; o_carry high in the cycle count=59; o_wrapped high for exactly the one cycle after.
REQ-035 SHALL verify the down-count wrap: load 1, then i_en=1, i_dir=0 for 3 clocks -> 1, 0, 59, 58; o_at_min high only while count=0.
REQ-036 SHALL verify load clamping and priority: i_load_value=200 -> count 59; i_clr=1, i_load=1, i_en=1 together -> count 0, o_carry=0.
REQ-037 SHALL verify saturation: SATURATE=1, MODULUS=10, up-count 15 clocks -> count stops at 9; down-count 15 clocks -> count stops at 0; o_carry and o_wrapped never assert.
REQ-038 SHALL verify reset mid-operation: assert i_reset asynchronously between edges at count=37 while o_wrapped=1 -> count=RESET_VALUE and o_wrapped=0 before the next edge; counting resumes from RESET_VALUE after release.
REQ-039 SHALL verify the full-range cascade: two instances, WIDTH=4, MODULUS=16, low-stage o_carry into high-stage i_en, 256 up-count clocks -> combined value increments 0..255 and then returns to 0.
